tetris_key_repeat: RTL and testbench
====================================

# tetris_key_repeat

Converts each player's filtered USB keycode into frame-aligned key events with delayed auto-repeat, so a held key produces one move and then repeats at a controlled rate. Sits between `keycode_filter` and the per-player game logic (`ball`, `ball_two`, `fsm`), all of which are clocked by `vsync`. Runs on the 100 MHz system clock and outputs keycodes that change only just after each `vsync` rising edge.

## Interface
- `DAS_FRAMES`, 10: frames between the first event and the first repeat. Range 2..63.
- `ARR_FRAMES`, 3: frames between successive repeats. Range 1..63.
- `NOREP_KEY1`, 8'h1A: player-1 keycode that never repeats (rotate).
- `NOREP_KEY2`, 8'h52: player-2 keycode that never repeats (rotate).
- `Clk`  in  1  100 MHz system clock. This is the only clock.
- `reset_rtl_0`  in  1  Asynchronous, active-low reset.
- `vsync_in`  in  1  VGA vsync from the 25 MHz domain. Asynchronous to `Clk`.
- `player1key`  in  8  Filtered player-1 keycode. 0 means no key.
- `player2key`  in  8  Filtered player-2 keycode. 0 means no key.
- `p1_evt_key`  out  8  Player-1 event keycode, held for one frame. 0 means no event.
- `p2_evt_key`  out  8  Player-2 event keycode, held for one frame. 0 means no event.
- `frame_tick`  out  1  One-`Clk` pulse at each detected frame boundary.

## Operation
- **Frame detect:** `vsync_in` passes through a 2-flop synchronizer. A rising edge of the synchronized signal raises `frame_tick`.
- **Per-player FSM:** two identical, independent instances. Each has state IDLE/DELAY/REPEAT/HOLD, `last_key` (8 bits) and a 6-bit counter `cnt`. Evaluation happens only on `frame_tick`; at all other times state and outputs hold.
- **Transitions**, with `k` = the current input keycode sampled on `frame_tick`:
  - `k==0`: go to IDLE, output 0, `cnt`=0, `last_key`=0.
  - `k!=0 && k!=last_key` (new press, or a direct change to another key):
    - output `k`, `last_key`=`k`, `cnt`=0.
    - next state is HOLD if `k` equals that player's NOREP key, otherwise DELAY.
  - DELAY with `k==last_key`: `cnt`++.
    - When `cnt` reaches `DAS_FRAMES-1`: output `k`, `cnt`=0, go to REPEAT.
    - Otherwise output 0.
  - REPEAT with `k==last_key`: `cnt`++.
    - When `cnt` reaches `ARR_FRAMES-1`: output `k`, `cnt`=0.
    - Otherwise output 0.
    - With `ARR_FRAMES`=1, an event is emitted every frame.
  - HOLD with `k==last_key`: output 0 indefinitely.
- **Net effect:** a key pressed at tick N emits at N, N+`DAS_FRAMES`, N+`DAS_FRAMES`+`ARR_FRAMES`, and so on.
- **Counter width:** `cnt` compares against parameter-1 at 6 bits. It never wraps, because it is cleared at each terminal count.
- **Boundaries:**
  - Events from the two players may coincide; neither blocks the other.
  - A key changing between ticks is not seen; only the value at the tick counts.
  - Input glitches between ticks are ignored.

## Timing
- `frame_tick` asserts 3 `Clk` cycles after the `vsync_in` rise: 2 synchronizer flops plus 1 edge register.
- Event outputs are registered. They update on the `Clk` edge after `frame_tick`, at most 4 cycles (40 ns) after the `vsync_in` rise.
- Outputs are otherwise stable for the whole frame. `vsync`-clocked consumers therefore sample each event exactly once, at the next `vsync` rise.
- **Reset values:** all outputs 0, both FSMs IDLE, `cnt`=0, `last_key`=0, synchronizer flops 0.
- **Reset asserted mid-operation:** everything clears immediately. A key held through reset release is treated as a new press at the first tick.
- A `vsync_in` high at reset release produces no tick until a genuine low-to-high transition.

## Configuration
- `TETRIS_KEY_AUTOREPEAT_EN`
  - **Defined:** behaviour exactly as described above.
  - **Undefined:** DELAY and REPEAT are not built. Every non-NOREP press goes to HOLD, so only press and key-change events are emitted. `DAS_FRAMES` and `ARR_FRAMES` are ignored.

## Test plan
- **Reset:** hold `reset_rtl_0`=0 with `player1key`=8'h04 and toggle `vsync_in` → both event outputs stay 0 and `frame_tick` stays 0. Release reset → `p1_evt_key`=8'h04 on the first tick.
- **Auto-repeat:** defaults; `player1key`=8'h07 held for 20 ticks starting at tick 0 → events at ticks 0, 10, 13, 16, 19. Each event lasts exactly one frame; output is 0 on all other frames.
- **No-repeat key:** `player1key`=8'h1A held for 30 ticks → a single event at tick 0. Release for 1 tick and press again → a new event.
- **Key change while held:** 8'h04 for 5 ticks, then 8'h07 → event 8'h07 at tick 5. Its first repeat is at tick 15.
- **Independent players:** `player1key`=8'h04 and `player2key`=8'h50 both change at tick 0 → both outputs are nonzero on the same frame, and their repeat schedules are identical and independent.
- **Latency:** measure from the `vsync_in` rise → `frame_tick` at +3 `Clk` and outputs at +4 `Clk`. With the macro undefined, 8'h07 held for 20 ticks → a single event.

Source files
------------

// File: rtl/tetris_key_repeat.sv
// tetris_key_repeat: turns each player's filtered keycode into vsync-aligned key events with delayed auto-repeat.
// Build option: define TETRIS_KEY_AUTOREPEAT_EN to build the DAS/ARR repeat path; otherwise only press/change events are emitted.

module tetris_key_repeat_fsm #(
    parameter int         DAS_FRAMES = 10,
    parameter int         ARR_FRAMES = 3,
    parameter logic [7:0] NOREP_KEY  = 8'h1A
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [7:0] key,
    output logic [7:0] evt_key
);
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT, HOLD} state_t;

    state_t     state;
    logic [7:0] last_key;

`ifdef TETRIS_KEY_AUTOREPEAT_EN
    localparam logic [5:0] DAS_TC = 6'(DAS_FRAMES - 1);
    localparam logic [5:0] ARR_TC = 6'(ARR_FRAMES - 1);
    logic [5:0] cnt;
`else
    // Repeat timing has no effect in this build; kept only so the interface is identical.
    logic unused_cfg;
    assign unused_cfg = ^{6'(DAS_FRAMES), 6'(ARR_FRAMES), NOREP_KEY};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_key <= '0;
            evt_key  <= '0;
`ifdef TETRIS_KEY_AUTOREPEAT_EN
            cnt      <= '0;
`endif
        end else if (tick) begin
            if (key == 8'h00) begin
                state    <= IDLE;
                last_key <= '0;
                evt_key  <= '0;
`ifdef TETRIS_KEY_AUTOREPEAT_EN
                cnt      <= '0;
`endif
            end else if (key != last_key) begin
                last_key <= key;
                evt_key  <= key;
`ifdef TETRIS_KEY_AUTOREPEAT_EN
                cnt      <= '0;
                state    <= (key == NOREP_KEY) ? HOLD : DELAY;
`else
                state    <= HOLD;
`endif
            end else begin
                case (state)
`ifdef TETRIS_KEY_AUTOREPEAT_EN
                    DELAY: begin
                        if (cnt == DAS_TC) begin
                            evt_key <= key;
                            cnt     <= '0;
                            state   <= REPEAT;
                        end else begin
                            evt_key <= '0;
                            cnt     <= cnt + 6'd1;
                        end
                    end
                    REPEAT: begin
                        if (cnt == ARR_TC) begin
                            evt_key <= key;
                            cnt     <= '0;
                        end else begin
                            evt_key <= '0;
                            cnt     <= cnt + 6'd1;
                        end
                    end
`endif
                    // HOLD stays silent; IDLE cannot see an unchanged nonzero key.
                    default: evt_key <= '0;
                endcase
            end
        end
    end
endmodule

module tetris_key_repeat #(
    parameter int         DAS_FRAMES = 10,
    parameter int         ARR_FRAMES = 3,
    parameter logic [7:0] NOREP_KEY1 = 8'h1A,
    parameter logic [7:0] NOREP_KEY2 = 8'h52
) (
    input  logic       Clk,
    input  logic       reset_rtl_0,
    input  logic       vsync_in,
    input  logic [7:0] player1key,
    input  logic [7:0] player2key,
    output logic [7:0] p1_evt_key,
    output logic [7:0] p2_evt_key,
    output logic       frame_tick
);
    logic vsync_p0, vsync_p1, vsync_p2;
    logic vld_p0, vld_p1, vld_p2;

    // p0/p1 synchronize vsync, p2 is the edge register. vld_pN marks a stage holding a
    // real sample, so a vsync already high at reset release is not mistaken for a rise.
    always_ff @(posedge Clk or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            vsync_p0   <= 1'b0;
            vsync_p1   <= 1'b0;
            vsync_p2   <= 1'b0;
            vld_p0     <= 1'b0;
            vld_p1     <= 1'b0;
            vld_p2     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            vsync_p0   <= vsync_in;
            vsync_p1   <= vsync_p0;
            vsync_p2   <= vsync_p1;
            vld_p0     <= 1'b1;
            vld_p1     <= vld_p0;
            vld_p2     <= vld_p1;
            frame_tick <= vld_p2 && vsync_p1 && !vsync_p2;
        end
    end

    tetris_key_repeat_fsm #(
        .DAS_FRAMES (DAS_FRAMES),
        .ARR_FRAMES (ARR_FRAMES),
        .NOREP_KEY  (NOREP_KEY1)
    ) u_p1 (
        .clk     (Clk),
        .rst_n   (reset_rtl_0),
        .tick    (frame_tick),
        .key     (player1key),
        .evt_key (p1_evt_key)
    );

    tetris_key_repeat_fsm #(
        .DAS_FRAMES (DAS_FRAMES),
        .ARR_FRAMES (ARR_FRAMES),
        .NOREP_KEY  (NOREP_KEY2)
    ) u_p2 (
        .clk     (Clk),
        .rst_n   (reset_rtl_0),
        .tick    (frame_tick),
        .key     (player2key),
        .evt_key (p2_evt_key)
    );
endmodule

// File: tb/tb_tetris_key_repeat.sv
// Randomized self-checking bench for tetris_key_repeat against a tick-indexed event-schedule model.
module tb_tetris_key_repeat;
`ifdef TETRIS_KEY_AUTOREPEAT_EN
    localparam int DAS = 10;
    localparam int ARR = 3;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vsync = 1'b0;
    logic [7:0] k1 = 8'h00;
    logic [7:0] k2 = 8'h00;
    logic [7:0] p1_evt;
    logic [7:0] p2_evt;
    logic       frame_tick;

    int n_chk = 0;
    int n_bad = 0;
    int tick_seen = 0;

    // Model: last key per player, tick of its press, and a running tick number.
    logic [7:0] m_last [2];
    int         m_start [2];
    int         tick_no = 0;
    logic [7:0] prev_e1 = 8'h00;
    logic [7:0] prev_e2 = 8'h00;

    tetris_key_repeat dut (
        .Clk         (clk),
        .reset_rtl_0 (rst_n),
        .vsync_in    (vsync),
        .player1key  (k1),
        .player2key  (k2),
        .p1_evt_key  (p1_evt),
        .p2_evt_key  (p2_evt),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (frame_tick) tick_seen <= tick_seen + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_step(input int p, input logic [7:0] k);
`ifdef TETRIS_KEY_AUTOREPEAT_EN
        int age;
        logic [7:0] norep;
        norep = (p == 0) ? 8'h1A : 8'h52;
`endif
        if (k == 8'h00) begin
            m_last[p] = 8'h00;
            return 8'h00;
        end
        if (k != m_last[p]) begin
            m_last[p]  = k;
            m_start[p] = tick_no;
            return k;
        end
`ifdef TETRIS_KEY_AUTOREPEAT_EN
        age = tick_no - m_start[p];
        if (k != norep && age >= DAS && ((age - DAS) % ARR) == 0) return k;
`endif
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_last[0] = 8'h00;
        m_last[1] = 8'h00;
        prev_e1   = 8'h00;
        prev_e2   = 8'h00;
    endtask

    // One frame: keys set while vsync is low (optionally glitched and restored), then a vsync rise.
    task automatic frame(input logic [7:0] a, input logic [7:0] b, input bit glitch);
        logic [7:0] e1, e2;
        int t0;
        @(posedge clk); #1;
        check_eq("p1_hold", p1_evt, prev_e1);
        check_eq("p2_hold", p2_evt, prev_e2);
        k1 = a;
        k2 = b;
        if (glitch) begin
            repeat (2) @(posedge clk); #1;
            k1 = 8'($urandom);
            k2 = 8'($urandom);
            @(posedge clk); #1;
            k1 = a;
            k2 = b;
        end
        repeat (3) @(posedge clk); #1;
        t0 = tick_seen;
        vsync = 1'b1;
        e1 = model_step(0, a);
        e2 = model_step(1, b);
        tick_no++;
        repeat (6) @(posedge clk); #1;
        check_eq("p1_evt", p1_evt, e1);
        check_eq("p2_evt", p2_evt, e2);
        check_eq("one_tick", tick_seen - t0, 1);
        prev_e1 = e1;
        prev_e2 = e2;
        vsync = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic latency(input logic [7:0] a);
        logic [7:0] e1;
        repeat (4) @(posedge clk); #1;
        k1 = a;
        repeat (3) @(posedge clk);
        #1 vsync = 1'b1;
        e1 = model_step(0, a);
        void'(model_step(1, k2));
        tick_no++;
        repeat (2) @(posedge clk); #1;
        check_eq("lat_tick_early", frame_tick, 0);
        @(posedge clk); #1;
        check_eq("lat_tick_3", frame_tick, 1);
        check_eq("lat_out_not_yet", p1_evt, prev_e1);
        @(posedge clk); #1;
        check_eq("lat_out_4", p1_evt, e1);
        check_eq("lat_tick_gone", frame_tick, 0);
        prev_e1 = e1;
        vsync = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r1, r2;
        logic [7:0] pool1 [4] = '{8'h00, 8'h04, 8'h07, 8'h1A};
        logic [7:0] pool2 [4] = '{8'h00, 8'h50, 8'h51, 8'h52};
        model_reset();

        // Reset held: vsync toggling must produce nothing.
        k1 = 8'h04;
        for (int i = 0; i < 3; i++) begin
            repeat (3) @(posedge clk); #1 vsync = 1'b1;
            repeat (5) @(posedge clk); #1;
            check_eq("rst_p1", p1_evt, 0);
            check_eq("rst_p2", p2_evt, 0);
            check_eq("rst_tick", frame_tick, 0);
            vsync = 1'b0;
        end
        check_eq("rst_no_ticks", tick_seen, 0);
        repeat (3) @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        frame(8'h04, 8'h00, 1'b0);

        // Held key with auto-repeat schedule, then release.
        for (int i = 0; i < 20; i++) frame(8'h07, 8'h00, 1'b0);
        frame(8'h00, 8'h00, 1'b0);

        // Non-repeating key, release, press again.
        for (int i = 0; i < 30; i++) frame(8'h1A, 8'h00, 1'b0);
        frame(8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 2; i++) frame(8'h1A, 8'h00, 1'b0);

        // Direct key change while held.
        for (int i = 0; i < 5; i++) frame(8'h04, 8'h00, 1'b0);
        for (int i = 0; i < 12; i++) frame(8'h07, 8'h00, 1'b0);

        // Both players together, then p2 non-repeat key alongside p1 repeat.
        for (int i = 0; i < 15; i++) frame(8'h04, 8'h50, 1'b0);
        for (int i = 0; i < 12; i++) frame(8'h04, 8'h52, 1'b1);

        // Randomized holds, changes and between-tick glitches.
        r1 = 8'h00;
        r2 = 8'h00;
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 9) < 2) r1 = pool1[$urandom_range(0, 3)];
            if ($urandom_range(0, 9) < 2) r2 = pool2[$urandom_range(0, 3)];
            frame(r1, r2, 1'($urandom_range(0, 1)));
        end

        // Latency from the vsync rise.
        frame(8'h00, 8'h00, 1'b0);
        latency(8'h07);

        // Reset mid-operation, released while vsync is high.
        for (int i = 0; i < 3; i++) frame(8'h07, 8'h51, 1'b0);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        check_eq("midrst_p1", p1_evt, 0);
        check_eq("midrst_p2", p2_evt, 0);
        model_reset();
        vsync = 1'b1;
        repeat (2) @(posedge clk); #1 rst_n = 1'b1;
        begin
            int t0;
            t0 = tick_seen;
            repeat (10) @(posedge clk); #1;
            check_eq("high_at_release_no_tick", tick_seen - t0, 0);
        end
        vsync = 1'b0;
        repeat (3) @(posedge clk);
        for (int i = 0; i < 14; i++) frame(8'h07, 8'h51, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
